// File: rtl/store_drain_unit.sv
`default_nettype none
// ============================================================================
// Module   : store_drain_unit
// Purpose  : Back end of the store path. Holds stores retired by the ROB in a
//            FIFO, in program order, and drains them to data memory over a
//            req/ack handshake. Byte enables and lane-replicated write data
//            are generated per access. Misaligned or illegal entries are
//            discarded in order and reported with a one-cycle pulse.
// Ports    : clk, reset_n (async, active-low)
//            commit_valid/addr/data/funct3/inst_num -> push side
//            commit_ready                           <- queue not full
//            dmem_req/addr/wdata/be, dmem_ack       -> memory handshake
//            drain_done, drain_inst_num             <- store reached memory
//            misalign_err                           <- entry discarded
//            overflow (sticky), empty, count        <- status
//            ld_check_addr / ld_hazard              <- only with the macro
//                                                      STORE_DRAIN_HAZARD_EN
// Revision : 1.0 - initial release
// ============================================================================
module store_drain_unit #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              commit_valid,
    input  logic [31:0]       commit_addr,
    input  logic [31:0]       commit_data,
    input  logic [2:0]        commit_funct3,
    input  logic [31:0]       commit_inst_num,
    output logic              commit_ready,
    output logic              dmem_req,
    output logic [31:0]       dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    output logic              drain_done,
    output logic [31:0]       drain_inst_num,
    output logic              misalign_err,
    output logic              overflow,
    output logic              empty,
`ifdef STORE_DRAIN_HAZARD_EN
    input  logic [31:0]       ld_check_addr,
    output logic              ld_hazard,
`endif
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_one_cnt  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Entry storage (no reset needed: validity comes from head/count)
    // ------------------------------------------------------------------
    logic [31:0] mem_addr_q   [DEPTH];
    logic [31:0] mem_data_q   [DEPTH];
    logic [2:0]  mem_funct3_q [DEPTH];
    logic [31:0] mem_inst_q   [DEPTH];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [0:0]       state_q,        state_d;
    logic [PTR_W-1:0] head_q,         head_d;
    logic [PTR_W-1:0] tail_q,         tail_d;
    logic [CNT_W-1:0] count_q,        count_d;
    logic             dmem_req_q,     dmem_req_d;
    logic [31:0]      dmem_addr_q,    dmem_addr_d;
    logic [31:0]      dmem_wdata_q,   dmem_wdata_d;
    logic [3:0]       dmem_be_q,      dmem_be_d;
    logic             drain_done_q,   drain_done_d;
    logic [31:0]      drain_inst_q,   drain_inst_d;
    logic             misalign_q,     misalign_d;
    logic             overflow_q,     overflow_d;

    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_head_nxt;
    logic [PTR_W-1:0] w_sel_idx;
    logic             w_sel_legal;
    logic [31:0]      w_sel_addr;
    logic [31:0]      w_sel_wdata;
    logic [3:0]       w_sel_be;

    function automatic logic is_legal(input logic [31:0] a, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~a[0];
            3'b010:  ok = (a[1:0] == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lane_be(input logic [31:0] a, input logic [2:0] f3);
        logic [3:0] be;
        case (f3)
            3'b000:  be = 4'b0001 << a[1:0];
            3'b001:  be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_data(input logic [31:0] d, input logic [2:0] f3);
        logic [31:0] w;
        case (f3)
            3'b000:  w = {4{d[7:0]}};
            3'b001:  w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    assign commit_ready = (count_q != c_full_cnt);
    assign w_push       = commit_valid && commit_ready;
    assign w_head_nxt   = head_q + 1'b1;

    // In IDLE the candidate is the head; in BUSY it is the entry behind the
    // in-flight head, which is what a back-to-back reload must launch.
    assign w_sel_idx   = (state_q == BUSY) ? w_head_nxt : head_q;
    assign w_sel_legal = is_legal(mem_addr_q[w_sel_idx], mem_funct3_q[w_sel_idx]);
    assign w_sel_addr  = {mem_addr_q[w_sel_idx][31:2], 2'b00};
    assign w_sel_be    = lane_be(mem_addr_q[w_sel_idx], mem_funct3_q[w_sel_idx]);
    assign w_sel_wdata = lane_data(mem_data_q[w_sel_idx], mem_funct3_q[w_sel_idx]);

    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        drain_done_d = 1'b0;
        drain_inst_d = drain_inst_q;
        misalign_d   = 1'b0;
        overflow_d   = overflow_q | (commit_valid & ~commit_ready);
        w_pop        = 1'b0;

        case (state_q)
            IDLE: begin
                // Head is judged from registered count only, so a store
                // pushed this cycle is looked at on the next one.
                if (count_q != '0) begin
                    if (w_sel_legal) begin
                        dmem_req_d   = 1'b1;
                        dmem_addr_d  = w_sel_addr;
                        dmem_wdata_d = w_sel_wdata;
                        dmem_be_d    = w_sel_be;
                        state_d      = BUSY;
                    end else begin
                        w_pop      = 1'b1;
                        misalign_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    w_pop        = 1'b1;
                    drain_done_d = 1'b1;
                    drain_inst_d = mem_inst_q[head_q];
                    // Only a legal follower is launched without a bubble; an
                    // illegal one is discarded from IDLE on the next cycle.
                    if ((count_q != c_one_cnt) && w_sel_legal) begin
                        dmem_addr_d  = w_sel_addr;
                        dmem_wdata_d = w_sel_wdata;
                        dmem_be_d    = w_sel_be;
                    end else begin
                        dmem_req_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            default: begin
                dmem_req_d = 1'b0;
                state_d    = IDLE;
            end
        endcase

        head_d  = w_pop  ? w_head_nxt    : head_q;
        tail_d  = w_push ? tail_q + 1'b1 : tail_q;
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_addr_q[tail_q]   <= commit_addr;
            mem_data_q[tail_q]   <= commit_data;
            mem_funct3_q[tail_q] <= commit_funct3;
            mem_inst_q[tail_q]   <= commit_inst_num;
        end
    end

    // Asynchronous reset drops dmem_req immediately; the in-flight entry
    // is abandoned along with the rest of the queue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            dmem_req_q   <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_be_q    <= '0;
            drain_done_q <= 1'b0;
            drain_inst_q <= '0;
            misalign_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            dmem_req_q   <= dmem_req_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_be_q    <= dmem_be_d;
            drain_done_q <= drain_done_d;
            drain_inst_q <= drain_inst_d;
            misalign_q   <= misalign_d;
            overflow_q   <= overflow_d;
        end
    end

    assign dmem_req       = dmem_req_q;
    assign dmem_addr      = dmem_addr_q;
    assign dmem_wdata     = dmem_wdata_q;
    assign dmem_be        = dmem_be_q;
    assign drain_done     = drain_done_q;
    assign drain_inst_num = drain_inst_q;
    assign misalign_err   = misalign_q;
    assign overflow       = overflow_q;
    assign count          = count_q;
    assign empty          = (count_q == '0) && !dmem_req_q;

`ifdef STORE_DRAIN_HAZARD_EN
    // An entry is live when its distance from head is below count. The
    // in-flight store is still at head until acked, but the request
    // register is also compared so the window is covered explicitly.
    logic [DEPTH-1:0] w_hit;
    logic             w_unused_ld_lsb;

    for (genvar i = 0; i < DEPTH; i++) begin : g_hazard_entry
        logic [PTR_W-1:0] w_off;
        assign w_off    = PTR_W'(i) - head_q;
        assign w_hit[i] = (CNT_W'(w_off) < count_q) &&
                          (mem_addr_q[i][31:2] == ld_check_addr[31:2]);
    end

    assign w_unused_ld_lsb = ^ld_check_addr[1:0];
    assign ld_hazard = (|w_hit) ||
                       (dmem_req_q && (dmem_addr_q[31:2] == ld_check_addr[31:2]));
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_drain_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_drain_unit
// Purpose  : Self-checking bench for store_drain_unit. A queue-based model of
//            committed stores predicts drain order, lane data, counts and
//            status every cycle; directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_drain_unit;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic              clk;
    logic              reset_n;
    logic              commit_valid;
    logic [31:0]       commit_addr;
    logic [31:0]       commit_data;
    logic [2:0]        commit_funct3;
    logic [31:0]       commit_inst_num;
    logic              commit_ready;
    logic              dmem_req;
    logic [31:0]       dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [3:0]        dmem_be;
    logic              dmem_ack;
    logic              drain_done;
    logic [31:0]       drain_inst_num;
    logic              misalign_err;
    logic              overflow;
    logic              empty;
    logic [CNT_W-1:0]  count;
`ifdef STORE_DRAIN_HAZARD_EN
    logic [31:0]       ld_check_addr;
    logic              ld_hazard;
`endif

    store_drain_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .commit_valid    (commit_valid),
        .commit_addr     (commit_addr),
        .commit_data     (commit_data),
        .commit_funct3   (commit_funct3),
        .commit_inst_num (commit_inst_num),
        .commit_ready    (commit_ready),
        .dmem_req        (dmem_req),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_be         (dmem_be),
        .dmem_ack        (dmem_ack),
        .drain_done      (drain_done),
        .drain_inst_num  (drain_inst_num),
        .misalign_err    (misalign_err),
        .overflow        (overflow),
        .empty           (empty),
`ifdef STORE_DRAIN_HAZARD_EN
        .ld_check_addr   (ld_check_addr),
        .ld_hazard       (ld_hazard),
`endif
        .count           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_drn  = 0;
    int n_mis  = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
        logic [31:0] inst;
    } st_t;

    st_t  mq[$];
    logic m_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit m_legal(input st_t s);
        case (s.f3)
            3'd0:    return 1'b1;
            3'd1:    return s.addr[0] == 1'b0;
            3'd2:    return s.addr[1:0] == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input st_t s);
        if (s.f3 == 3'd0) begin
            case (s.addr[1:0])
                2'd0:    return 4'b0001;
                2'd1:    return 4'b0010;
                2'd2:    return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        if (s.f3 == 3'd1) return s.addr[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input st_t s);
        if (s.f3 == 3'd0) return {s.data[7:0], s.data[7:0], s.data[7:0], s.data[7:0]};
        if (s.f3 == 3'd1) return {s.data[15:0], s.data[15:0]};
        return s.data;
    endfunction

    // Model update for pushes: a store is taken only if the model queue is
    // not full just before the edge.
    always @(posedge clk) begin
        if (reset_n && commit_valid) begin
            if (mq.size() == DEPTH) m_ovf <= 1'b1;
            else mq.push_back('{addr: commit_addr, data: commit_data,
                                f3: commit_funct3, inst: commit_inst_num});
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            mq.delete();
            m_ovf <= 1'b0;
            chk("rst_req",      dmem_req,     0);
            chk("rst_drain",    drain_done,   0);
            chk("rst_misalign", misalign_err, 0);
            chk("rst_overflow", overflow,     0);
            chk("rst_count",    count,        0);
            chk("rst_empty",    empty,        1);
            chk("rst_ready",    commit_ready, 1);
        end else begin
            if (drain_done) begin
                n_drn++;
                chk("drain_has_entry", mq.size() != 0, 1);
                if (mq.size() != 0) begin
                    chk("drain_inst",  drain_inst_num, mq[0].inst);
                    chk("drain_legal", m_legal(mq[0]), 1);
                    void'(mq.pop_front());
                end
            end
            if (misalign_err) begin
                n_mis++;
                chk("mis_has_entry", mq.size() != 0, 1);
                if (mq.size() != 0) begin
                    chk("mis_illegal", m_legal(mq[0]), 0);
                    void'(mq.pop_front());
                end
            end
            if (dmem_req) begin
                chk("req_has_entry", mq.size() != 0, 1);
                if (mq.size() != 0) begin
                    chk("req_legal", m_legal(mq[0]), 1);
                    chk("req_addr",  dmem_addr,  {mq[0].addr[31:2], 2'b00});
                    chk("req_be",    dmem_be,    m_be(mq[0]));
                    chk("req_wdata", dmem_wdata, m_wdata(mq[0]));
                end
            end
            chk("count",    count,        mq.size());
            chk("empty",    empty,        mq.size() == 0);
            chk("ready",    commit_ready, mq.size() != DEPTH);
            chk("overflow", overflow,     m_ovf);
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f3, input logic [31:0] inst);
        commit_valid    = 1'b1;
        commit_addr     = a;
        commit_data     = d;
        commit_funct3   = f3;
        commit_inst_num = inst;
        @(posedge clk);
        #1;
        commit_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n         = 1'b0;
        commit_valid    = 1'b0;
        commit_addr     = '0;
        commit_data     = '0;
        commit_funct3   = '0;
        commit_inst_num = '0;
        dmem_ack        = 1'b0;
`ifdef STORE_DRAIN_HAZARD_EN
        ld_check_addr   = '0;
`endif
        repeat (3) step();
        chk("lit_rst_empty", empty, 1);
        chk("lit_rst_ready", commit_ready, 1);
        reset_n = 1'b1;
        step();

        // 1: single SW, ack two cycles late
        push(32'h100, 32'hDEADBEEF, 3'b010, 32'h11);
        chk("t1_no_req_yet", dmem_req, 0);
        chk("t1_count1", count, 1);
        step();
        chk("t1_req", dmem_req, 1);
        chk("t1_addr", dmem_addr, 32'h100);
        chk("t1_be", dmem_be, 4'b1111);
        chk("t1_wdata", dmem_wdata, 32'hDEADBEEF);
        step();
        chk("t1_req_hold1", dmem_req, 1);
        step();
        chk("t1_req_hold2", dmem_req, 1);
        chk("t1_wdata_hold", dmem_wdata, 32'hDEADBEEF);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("t1_done", drain_done, 1);
        chk("t1_inst", drain_inst_num, 32'h11);
        chk("t1_req_off", dmem_req, 0);
        step();
        chk("t1_done_pulse", drain_done, 0);
        chk("t1_empty", empty, 1);

        // 2: SB then SH, ack tied high, back-to-back
        dmem_ack = 1'b1;
        push(32'h203, 32'h000000A5, 3'b000, 32'h12);
        push(32'h206, 32'h00001234, 3'b001, 32'h13);
        chk("t2_b0_req", dmem_req, 1);
        chk("t2_b0_addr", dmem_addr, 32'h200);
        chk("t2_b0_be", dmem_be, 4'b1000);
        chk("t2_b0_wdata", dmem_wdata, 32'hA5A5A5A5);
        step();
        chk("t2_b1_req", dmem_req, 1);
        chk("t2_b1_addr", dmem_addr, 32'h204);
        chk("t2_b1_be", dmem_be, 4'b1100);
        chk("t2_b1_wdata", dmem_wdata, 32'h12341234);
        chk("t2_b0_inst", drain_inst_num, 32'h12);
        step();
        chk("t2_req_off", dmem_req, 0);
        chk("t2_b1_inst", drain_inst_num, 32'h13);
        chk("t2_empty", empty, 1);
        dmem_ack = 1'b0;
        step();

        // 3: misaligned SW sandwiched between two legal SWs
        n_drn = 0;
        n_mis = 0;
        dmem_ack = 1'b1;
        push(32'h400, 32'h11111111, 3'b010, 32'h21);
        push(32'h101, 32'h22222222, 3'b010, 32'h22);
        push(32'h408, 32'h33333333, 3'b010, 32'h23);
        repeat (20) step();
        chk("t3_misalign_pulses", n_mis, 1);
        chk("t3_drain_pulses", n_drn, 2);
        chk("t3_empty", empty, 1);
        dmem_ack = 1'b0;

        // 4: fill past DEPTH with ack held low
        for (int i = 0; i < DEPTH; i++)
            push(32'h500 + 32'(4 * i), 32'(i), 3'b010, 32'h40 + 32'(i));
        chk("t4_count_full", count, DEPTH);
        chk("t4_not_ready", commit_ready, 0);
        chk("t4_no_ovf_yet", overflow, 0);
        push(32'h600, 32'hFFFF, 3'b010, 32'h48);
        chk("t4_overflow", overflow, 1);
        chk("t4_count_held", count, DEPTH);
        dmem_ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (count == 0) break;
            step();
        end
        chk("t4_drained", count, 0);
        chk("t4_ovf_sticky", overflow, 1);
        dmem_ack = 1'b0;
        step();

        // 5: asynchronous reset while BUSY with three queued
        push(32'h700, 32'hA, 3'b010, 32'h50);
        push(32'h704, 32'hB, 3'b010, 32'h51);
        push(32'h708, 32'hC, 3'b010, 32'h52);
        step();
        chk("t5_busy_req", dmem_req, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_req_async_drop", dmem_req, 0);
        chk("t5_count_clr", count, 0);
        chk("t5_empty", empty, 1);
        chk("t5_ovf_clr", overflow, 0);
        step();
        step();
        reset_n = 1'b1;
        dmem_ack = 1'b1;
        n_drn = 0;
        repeat (10) step();
        chk("t5_no_drain", n_drn, 0);
        chk("t5_empty_after", empty, 1);
        dmem_ack = 1'b0;

`ifdef STORE_DRAIN_HAZARD_EN
        // 6: load hazard against a queued, then in-flight, then drained SB
        ld_check_addr = 32'h300;
        push(32'h302, 32'h5A, 3'b000, 32'h60);
        chk("t6_hazard_queued", ld_hazard, 1);
        ld_check_addr = 32'h304;
        #1;
        chk("t6_other_word", ld_hazard, 0);
        ld_check_addr = 32'h300;
        step();
        chk("t6_hazard_inflight", ld_hazard, 1);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("t6_drained", drain_done, 1);
        chk("t6_hazard_clear", ld_hazard, 0);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
